// File: rtl/load_imm_encoder.sv
`default_nettype none
// ============================================================================
// Module   : load_imm_encoder
// Brief    : Turns a 32-bit constant plus destination register into the RV32I
//            LUI / ADDI word sequence that rebuilds it, streamed over a
//            valid/ready interface. The lower 12 bits are sign-compensated by
//            rounding the upper field, so LUI hi + ADDI lo reproduces V.
// Revision : 1.0 - initial release
// ============================================================================
module load_imm_encoder #(
    parameter bit ALLOW_SHORT = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_value,
    input  logic [4:0]  in_rd,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_last
);

    localparam logic [1:0] c_ST_IDLE      = 2'd0;
    localparam logic [1:0] c_ST_EMIT_LUI  = 2'd1;
    localparam logic [1:0] c_ST_EMIT_ADDI = 2'd2;

    localparam logic [6:0] c_OP_LUI = 7'b0110111;
    localparam logic [6:0] c_OP_IMM = 7'b0010011;

    logic [1:0]  r_state;
    logic [1:0]  w_next_state;

    // Latched operands of the sequence currently being emitted
    logic [19:0] r_hi;
    logic [11:0] r_lo;
    logic [4:0]  r_rd;
    logic [4:0]  r_rs1;
    logic        r_two;

    logic        w_in_xfer;
    logic        w_out_xfer;
    logic [11:0] w_lo;
    logic [19:0] w_hi;
    logic        w_fits12;

    // Values chosen for the incoming constant by the selection rules
    logic [1:0]  w_start_state;
    logic        w_two;
    logic [11:0] w_sel_lo;
    logic [4:0]  w_sel_rd;
    logic [4:0]  w_sel_rs1;

    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = out_valid && out_ready;

    // Adding 0x800 before taking [31:12] only carries into bit 12 when bit 11
    // is set, so the rounding is an increment of the upper field by V[11].
    assign w_lo     = in_value[11:0];
    assign w_hi     = in_value[31:12] + {19'd0, in_value[11]};
    assign w_fits12 = (&in_value[31:11]) | ~(|in_value[31:11]);

    // Choose the sequence shape and the operand fields for a new constant
    always_comb begin
        w_start_state = c_ST_EMIT_LUI;
        w_two         = 1'b1;
        w_sel_lo      = w_lo;
        w_sel_rd      = in_rd;
        w_sel_rs1     = in_rd;
        if (ALLOW_SHORT) begin
            if (in_rd == 5'd0) begin
                // Writes to x0 are discarded: emit the canonical NOP
                w_start_state = c_ST_EMIT_ADDI;
                w_two         = 1'b0;
                w_sel_lo      = 12'd0;
                w_sel_rd      = 5'd0;
                w_sel_rs1     = 5'd0;
            end else if (w_fits12) begin
                w_start_state = c_ST_EMIT_ADDI;
                w_two         = 1'b0;
                w_sel_rs1     = 5'd0;
            end else if (w_lo == 12'd0) begin
                w_start_state = c_ST_EMIT_LUI;
                w_two         = 1'b0;
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Capture operands when a new constant is accepted
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi  <= 20'd0;
            r_lo  <= 12'd0;
            r_rd  <= 5'd0;
            r_rs1 <= 5'd0;
            r_two <= 1'b0;
        end else if (w_in_xfer) begin
            r_hi  <= w_hi;
            r_lo  <= w_sel_lo;
            r_rd  <= w_sel_rd;
            r_rs1 <= w_sel_rs1;
            r_two <= w_two;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_in_xfer) begin
                    w_next_state = w_start_state;
                end
            end
            c_ST_EMIT_LUI: begin
                if (w_out_xfer) begin
                    w_next_state = r_two ? c_ST_EMIT_ADDI : c_ST_IDLE;
                end
            end
            c_ST_EMIT_ADDI: begin
                if (w_out_xfer) begin
                    w_next_state = c_ST_IDLE;
                end
            end
            default: w_next_state = c_ST_IDLE;
        endcase
    end

    // Outputs depend only on registered state, so they hold under backpressure
    always_comb begin
        in_ready  = (r_state == c_ST_IDLE) && !reset;
        out_valid = 1'b0;
        out_instr = 32'h0;
        out_last  = 1'b0;
        case (r_state)
            c_ST_EMIT_LUI: begin
                out_valid = 1'b1;
                out_instr = {r_hi, r_rd, c_OP_LUI};
                out_last  = !r_two;
            end
            c_ST_EMIT_ADDI: begin
                out_valid = 1'b1;
                out_instr = {r_lo, r_rs1, 3'b000, r_rd, c_OP_IMM};
                out_last  = 1'b1;
            end
            default: begin
                out_valid = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_load_imm_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_imm_encoder
// Brief    : Self-checking bench for load_imm_encoder (short and long forms).
// Revision : 1.0 - initial release
// ============================================================================
module tb_load_imm_encoder;

    typedef logic [32:0] wq_t [$];   // {last, instr}

    typedef struct {
        logic [31:0] v;
        logic [4:0]  rd;
        int          n;
        logic [31:0] w0;
        logic [31:0] w1;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, out_valid, out_ready, out_last;
    logic [31:0] in_value, out_instr;
    logic [4:0]  in_rd;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last;
    logic [31:0] b_in_value, b_out_instr;
    logic [4:0]  b_in_rd;

    int checks   = 0;
    int failures = 0;

    logic [32:0] exp_q [$];
    logic [31:0] got   [$];

    always #5 clk = ~clk;

    load_imm_encoder #(.ALLOW_SHORT(1'b1)) u_dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_value(in_value), .in_rd(in_rd),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_last(out_last)
    );

    load_imm_encoder #(.ALLOW_SHORT(1'b0)) u_dut_long (
        .clk(clk), .reset(reset),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_value(b_in_value), .in_rd(b_in_rd),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_instr(b_out_instr), .out_last(b_out_last)
    );

    // Reference: expected word list computed from signed ranges and arithmetic
    function automatic wq_t model(input logic [31:0] v, input logic [4:0] rd, input bit allow);
        wq_t         q;
        int          sv;
        logic [31:0] hi, lo, rdw, lui, addi_x0, addi_rd;
        sv      = int'($signed(v));
        hi      = (v + 32'd2048) >> 12;
        lo      = v & 32'hFFF;
        rdw     = {27'd0, rd};
        lui     = (hi << 12) | (rdw << 7) | 32'h37;
        addi_x0 = (lo << 20) | (rdw << 7) | 32'h13;
        addi_rd = (lo << 20) | (rdw << 15) | (rdw << 7) | 32'h13;
        if (allow && rd == 5'd0)                   q.push_back({1'b1, 32'h00000013});
        else if (allow && sv >= -2048 && sv <= 2047) q.push_back({1'b1, addi_x0});
        else if (allow && lo == 32'd0)             q.push_back({1'b1, lui});
        else begin
            q.push_back({1'b0, lui});
            q.push_back({1'b1, addi_rd});
        end
        return q;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare DUT output against the model queue on every valid cycle
    always @(negedge clk) begin
        if (!reset && out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_word: got %h expected no word (t=%0t)", out_instr, $time);
            end else begin
                chk("model_instr", out_instr, exp_q[0][31:0]);
                chk("model_last", {31'd0, out_last}, {31'd0, exp_q[0][32]});
            end
        end
    end

    // Retire expected words on each output transfer
    always @(posedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            got.push_back(out_instr);
        end
    end

    task automatic send(input logic [31:0] v, input logic [4:0] rd);
        wq_t m;
        bit  ok;
        in_value = v;
        in_rd    = rd;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1'b1; break; end
        end
        if (!ok) chk("accept_timeout", 32'd0, 32'd1);
        m = model(v, rd, 1'b1);
        foreach (m[i]) exp_q.push_back(m[i]);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("latency_out_valid", {31'd0, out_valid}, 32'd1);
    endtask

    task automatic drain(input vec_t t);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin ok = 1'b1; break; end
        end
        if (!ok) chk("drain_timeout", 32'd0, 32'd1);
        chk("ready_return", {31'd0, in_ready}, 32'd1);
        chk("word_count", got.size(), t.n);
        if (got.size() > 0) chk("lit_word0", got[0], t.w0);
        if (t.n == 2 && got.size() > 1) chk("lit_word1", got[1], t.w1);
        got.delete();
        @(posedge clk); #1;
    endtask

    task automatic b_run(input logic [31:0] v, input logic [4:0] rd,
                         input logic [31:0] w0, input logic [31:0] w1);
        bit ok;
        logic [31:0] w;
        b_in_value = v;
        b_in_rd    = rd;
        b_in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (b_in_ready) begin ok = 1'b1; break; end
        end
        if (!ok) chk("long_accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            w = (k == 0) ? w0 : w1;
            ok = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (b_out_valid) begin ok = 1'b1; break; end
            end
            if (!ok) chk("long_word_timeout", 32'd0, 32'd1);
            chk("long_instr", b_out_instr, w);
            chk("long_last", {31'd0, b_out_last}, (k == 1) ? 32'd1 : 32'd0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("long_ready_return", {31'd0, b_in_ready}, 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[9];
        wq_t  m;
        vecs[0] = '{32'h00000005, 5'd5,  1, 32'h00500293, 32'h0};
        vecs[1] = '{32'h12345678, 5'd10, 2, 32'h12345537, 32'h67850513};
        vecs[2] = '{32'h00000800, 5'd1,  2, 32'h000010B7, 32'h80008093};
        vecs[3] = '{32'hFFFFF800, 5'd1,  1, 32'h80000093, 32'h0};
        vecs[4] = '{32'hFFFFFFFF, 5'd3,  1, 32'hFFF00193, 32'h0};
        vecs[5] = '{32'h7FFFF800, 5'd4,  2, 32'h80000237, 32'h80020213};
        vecs[6] = '{32'hABCDE000, 5'd2,  1, 32'hABCDE137, 32'h0};
        vecs[7] = '{32'h12345678, 5'd0,  1, 32'h00000013, 32'h0};
        vecs[8] = '{32'h00000000, 5'd7,  1, 32'h00000393, 32'h0};

        // Pin the model against hand-computed words
        m = model(32'h12345678, 5'd10, 1'b1);
        chk("model_pin_size", m.size(), 2);
        if (m.size() == 2) begin
            chk("model_pin_lui", m[0][31:0], 32'h12345537);
            chk("model_pin_addi", m[1][31:0], 32'h67850513);
        end
        m = model(32'h00000005, 5'd5, 1'b0);
        if (m.size() == 2) chk("model_pin_long", m[1][31:0], 32'h00528293);
        else chk("model_pin_long_size", m.size(), 2);

        reset      = 1'b1;
        in_valid   = 1'b0;
        in_value   = 32'h0;
        in_rd      = 5'd0;
        out_ready  = 1'b1;
        b_in_valid = 1'b0;
        b_in_value = 32'h0;
        b_in_rd    = 5'd0;
        b_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd0);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_out_instr", out_instr, 32'h0);
        chk("reset_out_last", {31'd0, out_last}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            send(vecs[i].v, vecs[i].rd);
            drain(vecs[i]);
        end

        // Backpressure: words must hold, new inputs must be refused
        out_ready = 1'b0;
        send(32'h12345678, 5'd10);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            in_valid = (i % 2 == 0);
            in_value = 32'hDEADBEEF;
            in_rd    = 5'd7;
            @(negedge clk);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_hold_instr", out_instr, 32'h12345537);
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain(vecs[1]);

        // Reset while the second word is pending
        send(32'h12345678, 5'd10);
        @(posedge clk); #1;
        chk("pre_reset_instr", out_instr, 32'h67850513);
        chk("pre_reset_last", {31'd0, out_last}, 32'd1);
        out_ready = 1'b0;
        reset     = 1'b1;
        exp_q.delete();
        got.delete();
        @(negedge clk);
        chk("midreset_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        reset     = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("post_reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("post_reset_out_instr", out_instr, 32'h0);
        chk("post_reset_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        send(32'h7FFFF800, 5'd4);
        drain(vecs[5]);

        // Always-two-word build
        b_run(32'h00000005, 5'd5, 32'h000002B7, 32'h00528293);
        b_run(32'h12345678, 5'd0, 32'h12345037, 32'h67800013);
        b_run(32'hFFFFFFFF, 5'd3, 32'h000001B7, 32'hFFF18193);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/load_imm_encoder.md
# load_imm_encoder

Sequential encoder that turns a 32-bit constant and a destination register into the RV32I instruction sequence that rebuilds it: a single ADDI, a single LUI, or a LUI followed by an ADDI. It performs the inverse of the 20→32 and 12→32 immediate sign extension done in the decode path, by splitting a 32-bit value into a 20-bit upper field and a sign-compensated 12-bit lower field. It sits between the test/boot loader and instruction memory and streams instruction words over a valid/ready interface.

## Interface
- ALLOW_SHORT, 1: when 1, values that fit in one instruction emit one word; when 0, every value emits LUI then ADDI.
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  in_value/in_rd are valid.
- in_ready  output  1  block can accept a new value.
- in_value  input  32  constant to load.
- in_rd  input  5  destination register index.
- out_valid  output  1  out_instr holds a valid instruction word.
- out_ready  input  1  consumer accepts out_instr this cycle.
- out_instr  output  32  encoded RV32I instruction.
- out_last  output  1  out_instr is the final word for the current value.

## Operation
- Reset values: in_ready=0 during reset and 1 on the first cycle after it; out_valid=0, out_instr=32'h0, out_last=0; FSM=IDLE.
- Input transfer: in_valid && in_ready. Output transfer: out_valid && out_ready.
- On input transfer, latch value V and rd. Compute:
  - lo = V[11:0].
  - hi = (V + 32'h800)[31:12]. This is 20-bit modular arithmetic, so carry out of bit 31 is discarded.
  - fits12 = (V[31:11] all 0s or all 1s).
- Encodings:
  - LUI = {hi, rd, 7'b0110111}.
  - ADDI = {imm12, rs1, 3'b000, rd, 7'b0010011}.
- Sequence selection, with ALLOW_SHORT=1:
  - rd==0 → single ADDI x0,x0,0 (32'h00000013).
  - fits12 → single ADDI rd,x0,lo.
  - lo==0 → single LUI rd,hi.
  - otherwise → LUI rd,hi, then ADDI rd,rd,lo.
- With ALLOW_SHORT=0, every value (including rd==0) emits LUI then ADDI rd,rd,lo.
- FSM states: IDLE, EMIT_LUI, EMIT_ADDI.
  - IDLE → EMIT_LUI or EMIT_ADDI on input transfer, chosen by the selection rules.
  - EMIT_LUI → EMIT_ADDI on output transfer if two words are needed, else → IDLE.
  - EMIT_ADDI → IDLE on output transfer.
- in_ready=1 only in IDLE. in_valid is ignored in the other states.
- out_last=1 in EMIT_ADDI, and in EMIT_LUI when LUI is the only word.

## Timing
- Latency: the first word has out_valid=1 in the cycle after the input transfer (registered output).
- Second word: presented in the cycle after the first word's output transfer.
- Return to IDLE: in_ready=1 in the cycle after the last word's output transfer.
- Maximum throughput: one value per 2 cycles for single-word sequences, one per 3 cycles for two-word sequences.
- Backpressure: while out_valid && !out_ready, out_instr and out_last stay stable and out_valid stays 1. out_valid never drops without a transfer, except on reset.
- Reset mid-sequence, in any state: the pending value is discarded and all outputs return to reset values in the next cycle. No partial sequence resumes.
- Wrap-around: V=32'h7FFFF800 gives hi=20'h80000 and lo=12'h800. LUI produces 0x80000000, and adding −2048 restores V.

## Test plan
- Reset, then in_value=32'h5, in_rd=5 → one word 32'h00500293 with out_last=1, one cycle after acceptance. in_ready returns 1 the cycle after the transfer.
- in_value=32'h12345678, in_rd=10, out_ready=1 → 32'h12345537 (out_last=0), then 32'h67850513 (out_last=1).
- Boundary values:
  - in_value=32'h00000800, rd=1 → 32'h000010B7, then 32'h80008093.
  - in_value=32'hFFFFF800, rd=1 → single 32'h80000093.
  - in_value=32'hFFFFFFFF, rd=3 → single 32'hFFF00193.
- Wrap and LUI-only cases:
  - in_value=32'h7FFFF800, rd=4 → 32'h80000237, then 32'h80020213.
  - in_value=32'hABCDE000, rd=2 → single 32'hABCDE137.
- Backpressure: hold out_ready=0 for 5 cycles during the 32'h12345678 sequence → out_instr stable and out_valid held. Toggle in_valid with a new value during this time → no acceptance (in_ready=0).
- Reset and parameter cases:
  - Assert reset while in EMIT_ADDI → the next cycle has out_valid=0, out_instr=0, and in_ready=1 after reset deasserts. A new value then encodes correctly.
  - ALLOW_SHORT=0 with in_value=32'h5, rd=5 → 32'h000002B7, then 32'h00528293.
